// File: rtl/shift_register.sv
// N-bit shift register with parallel load and left shift.
// Reset, load and shift act only on the rising clock edge. Reset has the
// highest priority, then load, then shift. When none of them is active, the
// register holds its value. PO is driven straight from the register, so no
// input has a combinational path to the output.
module shift_register #(
  parameter int N = 5
) (
  input  logic [N-1:0] PI,
  input  logic         clk,
  input  logic         rst,
  input  logic         sin,
  input  logic         ld,
  input  logic         shl,
  output logic [N-1:0] PO
);

  logic [N-1:0] r;

  // Update the data register once per rising edge, in priority order: rst, ld, shl.
  always_ff @(posedge clk) begin
    if (rst) begin
      r <= '0;
    end else if (ld) begin
      r <= PI;
    end else if (shl) begin
      r <= {r[N-2:0], sin};
    end
  end

  assign PO = r;

endmodule

// File: tb/tb_shift_register.sv
// Self-checking bench for shift_register. It runs two copies side by side,
// one at N=5 and one at N=10, with shared control inputs.
// Each applied operation pushes the expected contents of both registers into
// a scoreboard queue. The entries are popped and compared one time unit after
// the rising edge that should have produced them.
module tb_shift_register;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        sin = 1'b0;
  logic        ld  = 1'b0;
  logic        shl = 1'b0;
  logic [4:0]  pi5  = '0;
  logic [9:0]  pi10 = '0;
  logic [4:0]  po5;
  logic [9:0]  po10;

  logic [9:0]  model5;
  logic [9:0]  model10;
  logic [9:0]  q5[$];
  logic [9:0]  q10[$];

  int total = 0;
  int bad   = 0;

  // Both register widths use a 40 ns clock period.
  always #20 clk = ~clk;

  shift_register #(.N(5)) dut5 (
    .PI(pi5), .clk(clk), .rst(rst), .sin(sin), .ld(ld), .shl(shl), .PO(po5)
  );

  shift_register #(.N(10)) dut10 (
    .PI(pi10), .clk(clk), .rst(rst), .sin(sin), .ld(ld), .shl(shl), .PO(po10)
  );

  task automatic checkOutput(input string tag, input logic [9:0] observed,
                             input logic [9:0] expected);
    total++;
    if (observed !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %b expected %b", tag, observed, expected);
    end
  endtask

  // Compute the next register value from the behaviour the register must
  // have, then mask the result to the width of the register.
  function automatic logic [9:0] nextValue(input logic [9:0] cur, input int width,
                                           input logic r, input logic l,
                                           input logic s, input logic si,
                                           input logic [9:0] p);
    logic [9:0] mask;
    logic [9:0] res;
    mask = (10'h3FF >> (10 - width));
    if (r)      res = '0;
    else if (l) res = p;
    else if (s) res = {cur[8:0], si};
    else        res = cur;
    return res & mask;
  endfunction

  // Drive one operation at the falling edge and queue the expected results.
  // Wait for the rising edge, then pop the queue and compare both outputs.
  task automatic applyStimulus(input string tag, input logic r, input logic l,
                               input logic s, input logic si,
                               input logic [4:0] p5, input logic [9:0] p10);
    logic [9:0] e5;
    logic [9:0] e10;
    @(negedge clk);
    rst = r; ld = l; shl = s; sin = si; pi5 = p5; pi10 = p10;
    model5  = nextValue(model5, 5, r, l, s, si, {5'b0, p5});
    model10 = nextValue(model10, 10, r, l, s, si, p10);
    q5.push_back(model5);
    q10.push_back(model10);
    @(posedge clk);
    #1;
    e5  = q5.pop_front();
    e10 = q10.pop_front();
    checkOutput({tag, "/n5"}, {5'b0, po5}, e5);
    checkOutput({tag, "/n10"}, po10, e10);
  endtask

  logic [4:0] shiftSeq5 [5] = '{5'b01010, 5'b10100, 5'b01000, 5'b10000, 5'b00000};

  initial begin
    model5  = 'x;
    model10 = 'x;

    // Case 1: reset for one edge.
    applyStimulus("reset", 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 10'd0);
    checkOutput("reset_const", {5'b0, po5}, 10'd0);

    // Case 2: parallel load.
    applyStimulus("load", 1'b0, 1'b1, 1'b0, 1'b0, 5'd5, 10'd17);
    checkOutput("load_n5_const", {5'b0, po5}, 10'b0000000101);
    checkOutput("load_n10_const", po10, 10'b0000010001);

    // Case 3: five left shifts with sin=0.
    for (int i = 0; i < 5; i++) begin
      applyStimulus("shift0", 1'b0, 1'b0, 1'b1, 1'b0, 5'd0, 10'd0);
      checkOutput("shift0_n5_const", {5'b0, po5}, {5'b0, shiftSeq5[i]});
    end
    checkOutput("shift0_n10_const", po10, 10'd544);

    // Case 4: start from zero, shift in three ones, then hold for two edges.
    applyStimulus("clr", 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 10'd0);
    for (int i = 0; i < 3; i++)
      applyStimulus("shift1", 1'b0, 1'b0, 1'b1, 1'b1, 5'd0, 10'd0);
    checkOutput("shift1_n5_const", {5'b0, po5}, 10'b0000000111);
    for (int i = 0; i < 2; i++)
      applyStimulus("hold", 1'b0, 1'b0, 1'b0, 1'b1, 5'd0, 10'd0);
    checkOutput("hold_n5_const", {5'b0, po5}, 10'b0000000111);
    checkOutput("hold_n10_const", po10, 10'b0000000111);

    // Case 5: load wins over a simultaneous shift.
    applyStimulus("ldshl", 1'b0, 1'b1, 1'b1, 1'b1, 5'b10110, 10'h2B5);
    checkOutput("ldshl_n5_const", {5'b0, po5}, 10'b0000010110);
    checkOutput("ldshl_n10_const", po10, 10'h2B5);

    // Case 6: reset wins over a simultaneous load.
    applyStimulus("rstld", 1'b1, 1'b1, 1'b0, 1'b0, 5'b11111, 10'h3FF);
    checkOutput("rstld_n5_const", {5'b0, po5}, 10'd0);

    // Reload, pulse rst between edges, and check that the outputs do not move.
    applyStimulus("reload", 1'b0, 1'b1, 1'b0, 1'b0, 5'b11011, 10'h1A5);
    @(negedge clk);
    ld = 1'b0; shl = 1'b0;
    #5 rst = 1'b1;
    #5 rst = 1'b0;
    #1;
    checkOutput("midpulse_n5", {5'b0, po5}, 10'b0000011011);
    checkOutput("midpulse_n10", po10, 10'h1A5);
    @(posedge clk);
    #1;
    checkOutput("afterpulse_n5", {5'b0, po5}, 10'b0000011011);
    checkOutput("afterpulse_n10", po10, 10'h1A5);

    // Five ones shift in from a cleared register, so the 5-bit copy ends all ones.
    applyStimulus("clr2", 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 10'd0);
    for (int i = 0; i < 5; i++)
      applyStimulus("fill", 1'b0, 1'b0, 1'b1, 1'b1, 5'd0, 10'd0);
    checkOutput("fill_n5_const", {5'b0, po5}, 10'b0000011111);
    checkOutput("fill_n10_const", po10, 10'b0000011111);

    // Random mix of operations, with reset kept rare.
    for (int i = 0; i < 60; i++) begin
      applyStimulus("rand", ($urandom_range(15) == 0), ($urandom_range(3) == 0),
                    $urandom_range(1), $urandom_range(1),
                    5'($urandom), 10'($urandom));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
